// File: rtl/gate_resp_checker.sv
// gate_resp_checker: response checker for 2-input gate primitives.
// Accepts a valid/ready stream of (a, b, y) samples and compares each y
// against the TRUTH table indexed by {a,b}. It tracks coverage of the four
// input combinations, pass/fail counts and the first failing vector. A run
// ends on full coverage or when the sample budget is used up.
//
// Optional build macro: GATE_CHK_STOP_ON_FAIL_EN
//   defined   - the first mismatch of a run also ends the run
//   undefined - mismatches are only counted
module gate_resp_checker #(
  parameter logic [3:0] TRUTH       = 4'b1000,
  parameter int         CNT_W       = 8,
  parameter int         MAX_SAMPLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             s_a,
  input  logic             s_b,
  input  logic             s_y,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [3:0]       cov,
  output logic             done,
  output logic             pass,
  output logic             ff_vld,
  output logic [2:0]       ff_vec
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nx;

  logic             r_ready;
  logic [CNT_W-1:0] r_pass_cnt;
  logic [CNT_W-1:0] r_fail_cnt;
  logic [CNT_W-1:0] r_n;
  logic [3:0]       r_cov;
  logic             r_done;
  logic             r_pass;
  logic             r_ff_vld;
  logic [2:0]       r_ff_vec;

  logic [1:0]       w_idx;
  logic             w_xfer;
  logic             w_match;
  logic             w_clear;
  logic [3:0]       w_cov_nx;
  logic [CNT_W-1:0] w_pass_nx;
  logic [CNT_W-1:0] w_fail_nx;
  logic [CNT_W-1:0] w_n_nx;
  logic             w_full_cov;
  logic             w_budget;
  logic             w_stop_fail;
  logic             w_end;

  // Counter increment that holds at the all-ones value instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      return v;
    end
    return v + CNT_W'(1);
  endfunction

  // s_ready is only ever high in RUN, so a handshake implies RUN.
  assign w_idx      = {s_a, s_b};
  assign w_xfer     = s_valid & r_ready;
  assign w_match    = (s_y == TRUTH[w_idx]);
  assign w_clear    = start & (r_state != RUN);

  assign w_cov_nx   = r_cov | (4'b0001 << w_idx);
  assign w_pass_nx  = w_match ? sat_inc(r_pass_cnt) : r_pass_cnt;
  assign w_fail_nx  = w_match ? r_fail_cnt : sat_inc(r_fail_cnt);
  assign w_n_nx     = sat_inc(r_n);

  assign w_full_cov = (w_cov_nx == 4'b1111);
  assign w_budget   = (w_n_nx == CNT_W'(MAX_SAMPLES));
`ifdef GATE_CHK_STOP_ON_FAIL_EN
  assign w_stop_fail = ~w_match;
`else
  assign w_stop_fail = 1'b0;
`endif
  // Coverage, budget and (optionally) a mismatch collapse into one end event,
  // so coinciding causes still produce a single DONE entry.
  assign w_end      = w_xfer & (w_full_cov | w_budget | w_stop_fail);

  // Next-state logic: DONE is only left through a new start or reset.
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nx = RUN;
      RUN:     if (w_end) w_state_nx = DONE;
      DONE:    if (start) w_state_nx = RUN;
      default: w_state_nx = IDLE;
    endcase
  end

  // State register; s_ready is registered from the next state so it drops
  // in the same cycle done rises.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_ready <= (w_state_nx == RUN);
    end
  end

  // Result registers: cleared on a run start, updated on every transfer.
  always_ff @(posedge clk) begin
    if (rst || w_clear) begin
      r_pass_cnt <= '0;
      r_fail_cnt <= '0;
      r_n        <= '0;
      r_cov      <= '0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_ff_vld   <= 1'b0;
      r_ff_vec   <= '0;
    end else if (w_xfer) begin
      r_pass_cnt <= w_pass_nx;
      r_fail_cnt <= w_fail_nx;
      r_n        <= w_n_nx;
      r_cov      <= w_cov_nx;
      if (!w_match && !r_ff_vld) begin
        r_ff_vld <= 1'b1;
        r_ff_vec <= {s_a, s_b, s_y};
      end
      if (w_end) begin
        r_done <= 1'b1;
        r_pass <= w_full_cov & (w_fail_nx == '0);
      end
    end
  end

  assign s_ready  = r_ready;
  assign pass_cnt = r_pass_cnt;
  assign fail_cnt = r_fail_cnt;
  assign cov      = r_cov;
  assign done     = r_done;
  assign pass     = r_pass;
  assign ff_vld   = r_ff_vld;
  assign ff_vec   = r_ff_vec;

endmodule

// File: tb/tb_gate_resp_checker.sv
// Bench for gate_resp_checker: an AND checker and an XOR checker share the
// sample bus; a reference model pushes expected run results into a queue that
// a monitor pops when the selected checker raises done.
module tb_gate_resp_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start_a, start_x, valid_a, valid_x, sa, sb_in, sy;
  logic       rdy_a, done_a, pass_a, ffv_a, rdy_x, done_x, pass_x, ffv_x;
  logic [7:0] pc_a, fc_a, pc_x, fc_x;
  logic [3:0] cov_a, cov_x;
  logic [2:0] ffvec_a, ffvec_x;

  gate_resp_checker #(.TRUTH(4'b1000), .CNT_W(8), .MAX_SAMPLES(16)) u_and (
    .clk(clk), .rst(rst), .start(start_a), .s_valid(valid_a), .s_ready(rdy_a),
    .s_a(sa), .s_b(sb_in), .s_y(sy), .pass_cnt(pc_a), .fail_cnt(fc_a),
    .cov(cov_a), .done(done_a), .pass(pass_a), .ff_vld(ffv_a), .ff_vec(ffvec_a)
  );

  gate_resp_checker #(.TRUTH(4'b0110), .CNT_W(8), .MAX_SAMPLES(16)) u_xor (
    .clk(clk), .rst(rst), .start(start_x), .s_valid(valid_x), .s_ready(rdy_x),
    .s_a(sa), .s_b(sb_in), .s_y(sy), .pass_cnt(pc_x), .fail_cnt(fc_x),
    .cov(cov_x), .done(done_x), .pass(pass_x), .ff_vld(ffv_x), .ff_vec(ffvec_x)
  );

  int sel = 0;  // 0: AND checker, 1: XOR checker
  logic       d_rdy, d_done, d_pass, d_ffv;
  logic [7:0] d_pc, d_fc;
  logic [3:0] d_cov;
  logic [2:0] d_ffvec;

  always_comb begin
    d_rdy = rdy_a; d_done = done_a; d_pass = pass_a; d_ffv = ffv_a;
    d_pc = pc_a; d_fc = fc_a; d_cov = cov_a; d_ffvec = ffvec_a;
    if (sel == 1) begin
      d_rdy = rdy_x; d_done = done_x; d_pass = pass_x; d_ffv = ffv_x;
      d_pc = pc_x; d_fc = fc_x; d_cov = cov_x; d_ffvec = ffvec_x;
    end
  end

  typedef struct {
    logic       pass;
    logic [7:0] pc;
    logic [7:0] fc;
    logic [3:0] cov;
    logic       ffv;
    logic [2:0] ffvec;
  } exp_t;

  exp_t sb_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  // Reference model of one run.
  logic [3:0] mo_truth;
  logic [7:0] mo_pc, mo_fc;
  logic [3:0] mo_cov;
  int         mo_n;
  logic       mo_ffv;
  logic [2:0] mo_ffvec;
  bit         mo_run = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_start();
    mo_truth = (sel == 1) ? 4'b0110 : 4'b1000;
    mo_pc = 0; mo_fc = 0; mo_cov = 0; mo_n = 0; mo_ffv = 0; mo_ffvec = 0;
    mo_run = 1;
  endtask

  task automatic model_xfer(input logic a, input logic b, input logic y, output bit ended);
    logic [1:0] idx;
    logic       match;
    exp_t       e;
    idx   = {a, b};
    match = (y == mo_truth[idx]);
    if (match) begin
      if (mo_pc != 8'hFF) mo_pc = mo_pc + 8'd1;
    end else begin
      if (mo_fc != 8'hFF) mo_fc = mo_fc + 8'd1;
      if (!mo_ffv) begin mo_ffv = 1; mo_ffvec = {a, b, y}; end
    end
    mo_cov[idx] = 1'b1;
    mo_n = mo_n + 1;
    ended = (mo_cov == 4'b1111) || (mo_n == 16);
`ifdef GATE_CHK_STOP_ON_FAIL_EN
    if (!match) ended = 1;
`endif
    if (ended) begin
      e.pass = (mo_cov == 4'b1111) && (mo_fc == 0);
      e.pc = mo_pc; e.fc = mo_fc; e.cov = mo_cov; e.ffv = mo_ffv; e.ffvec = mo_ffvec;
      sb_q.push_back(e);
      mo_run = 0;
    end
  endtask

  task automatic do_start();
    if (sel == 1) start_x = 1; else start_a = 1;
    tick();
    start_x = 0; start_a = 0;
    model_start();
  endtask

  task automatic xfer(input logic a, input logic b, input logic y, input logic v,
                      output bit acc, output bit ended);
    bit rb;
    sa = a; sb_in = b; sy = y;
    if (sel == 1) valid_x = v; else valid_a = v;
    rb = d_rdy;
    tick();
    acc   = v && rb;
    ended = 0;
    if (acc && mo_run) model_xfer(a, b, y, ended);
  endtask

  // Scoreboard monitor: pop expected results when done rises.
  logic prev_done = 1'b0;
  exp_t m_e;
  always @(negedge clk) begin
    if (d_done === 1'b1 && prev_done !== 1'b1) begin
      if (sb_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL sb_unexpected_done: done rose with no expected result queued");
      end else begin
        m_e = sb_q.pop_front();
        n_tests++;
        if (d_pass !== m_e.pass) begin n_fail++; $display("FAIL sb_pass: got %0b expected %0b", d_pass, m_e.pass); end
        n_tests++;
        if (d_pc !== m_e.pc) begin n_fail++; $display("FAIL sb_pass_cnt: got %0d expected %0d", d_pc, m_e.pc); end
        n_tests++;
        if (d_fc !== m_e.fc) begin n_fail++; $display("FAIL sb_fail_cnt: got %0d expected %0d", d_fc, m_e.fc); end
        n_tests++;
        if (d_cov !== m_e.cov) begin n_fail++; $display("FAIL sb_cov: got %b expected %b", d_cov, m_e.cov); end
        n_tests++;
        if (d_ffv !== m_e.ffv) begin n_fail++; $display("FAIL sb_ff_vld: got %0b expected %0b", d_ffv, m_e.ffv); end
        n_tests++;
        if (d_ffvec !== m_e.ffvec) begin n_fail++; $display("FAIL sb_ff_vec: got %b expected %b", d_ffvec, m_e.ffvec); end
      end
    end
    prev_done = d_done;
  end

  task automatic test_reset();
    rst = 1; tick(); tick();
    n_tests++;
    if ({rdy_a, done_a, pass_a, ffv_a, pc_a, fc_a, cov_a, ffvec_a} !== 27'd0) begin
      n_fail++;
      $display("FAIL reset_and: got %h expected 0", {rdy_a, done_a, pass_a, ffv_a, pc_a, fc_a, cov_a, ffvec_a});
    end
    n_tests++;
    if ({rdy_x, done_x, pc_x, fc_x, cov_x} !== 22'd0) begin
      n_fail++;
      $display("FAIL reset_xor: got %h expected 0", {rdy_x, done_x, pc_x, fc_x, cov_x});
    end
    rst = 0; tick();
  endtask

  // Runs a 4-vector table, checking done/ready each cycle against the model's end point.
  task automatic run_table(input string nm, input logic [2:0] vecs [4]);
    bit acc, ended, seen_end;
    seen_end = 0;
    for (int i = 0; i < 4 && !seen_end; i++) begin
      xfer(vecs[i][2], vecs[i][1], vecs[i][0], 1'b1, acc, ended);
      seen_end = ended;
      n_tests++;
      if (d_done !== ended || d_rdy !== !ended) begin
        n_fail++;
        $display("FAIL %s_step%0d: done=%0b ready=%0b expected done=%0b ready=%0b",
                 nm, i, d_done, d_rdy, ended, !ended);
      end
    end
    if (sel == 1) valid_x = 0; else valid_a = 0;
    if (!seen_end) begin
      n_tests++; n_fail++;
      $display("FAIL %s_no_end: got no end, expected end within 4 transfers", nm);
    end
    tick();
  endtask

  task automatic test_and_pass();
    logic [2:0] v [4];
    v = '{3'b000, 3'b010, 3'b100, 3'b111};
    sel = 0; do_start();
    run_table("and_pass", v);
  endtask

  task automatic test_and_fail();
    logic [2:0] v [4];
    int exp_ffvec;
    v = '{3'b000, 3'b011, 3'b100, 3'b111};
    sel = 0; do_start();
    run_table("and_fail", v);
    exp_ffvec = 3;
    n_tests++;
    if (ffvec_a !== 3'(exp_ffvec) || ffv_a !== 1'b1) begin
      n_fail++;
      $display("FAIL and_fail_ffvec: got vld=%0b vec=%b expected vld=1 vec=011", ffv_a, ffvec_a);
    end
  endtask

  task automatic test_budget();
    bit acc, ended, seen_end;
    int nacc;
    logic [7:0] pc_hold;
    sel = 0; do_start();
    nacc = 0; seen_end = 0;
    for (int c = 0; c < 40 && !seen_end; c++) begin
      xfer(1'b0, 1'b0, 1'b0, (c % 2) == 0, acc, ended);
      if (acc) nacc++;
      seen_end = ended;
    end
    n_tests++;
    if (!seen_end || nacc != 16) begin
      n_fail++;
      $display("FAIL budget_end: got end=%0b after %0d transfers expected end after 16", seen_end, nacc);
    end
    pc_hold = pc_a;
    for (int c = 0; c < 3; c++) xfer(1'b0, 1'b0, 1'b0, 1'b1, acc, ended);
    n_tests++;
    if (rdy_a !== 1'b0 || pc_a !== pc_hold || done_a !== 1'b1) begin
      n_fail++;
      $display("FAIL budget_hold: got ready=%0b pass_cnt=%0d done=%0b expected ready=0 pass_cnt=%0d done=1",
               rdy_a, pc_a, done_a, pc_hold);
    end
    valid_a = 0; tick();
  endtask

  task automatic test_reset_midrun();
    bit acc, ended;
    sel = 0; do_start();
    xfer(1'b0, 1'b0, 1'b0, 1'b1, acc, ended);
    xfer(1'b0, 1'b1, 1'b0, 1'b1, acc, ended);
    valid_a = 0;
    n_tests++;
    if (pc_a !== 8'd2) begin n_fail++; $display("FAIL midrun_pre: got pass_cnt=%0d expected 2", pc_a); end
    rst = 1; start_a = 1; tick();
    rst = 0; start_a = 0; mo_run = 0;
    n_tests++;
    if ({rdy_a, done_a, pass_a, ffv_a, pc_a, fc_a, cov_a, ffvec_a} !== 27'd0) begin
      n_fail++;
      $display("FAIL midrun_reset: got %h expected 0", {rdy_a, done_a, pass_a, ffv_a, pc_a, fc_a, cov_a, ffvec_a});
    end
    for (int c = 0; c < 3; c++) xfer(1'b1, 1'b1, 1'b1, 1'b1, acc, ended);
    valid_a = 0;
    n_tests++;
    if (rdy_a !== 1'b0 || pc_a !== 8'd0 || cov_a !== 4'd0) begin
      n_fail++;
      $display("FAIL midrun_idle: got ready=%0b pass_cnt=%0d cov=%b expected 0 0 0000", rdy_a, pc_a, cov_a);
    end
  endtask

  task automatic test_restart();
    logic [2:0] v1 [4];
    logic [2:0] v2 [4];
    bit acc, ended;
    v1 = '{3'b001, 3'b010, 3'b100, 3'b111};
    v2 = '{3'b000, 3'b010, 3'b100, 3'b111};
    sel = 0; do_start();
    run_table("restart_first", v1);
    do_start();
    n_tests++;
    if ({done_a, pass_a, ffv_a, pc_a, fc_a, cov_a, ffvec_a} !== 26'd0 || rdy_a !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_clear: got ready=%0b rest=%h expected ready=1 rest=0",
               rdy_a, {done_a, pass_a, ffv_a, pc_a, fc_a, cov_a, ffvec_a});
    end
    start_a = 1;
    xfer(v2[0][2], v2[0][1], v2[0][0], 1'b1, acc, ended);
    start_a = 0;
    n_tests++;
    if (pc_a !== 8'd1 || cov_a !== 4'b0001 || rdy_a !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_start_in_run: got pass_cnt=%0d cov=%b ready=%0b expected 1 0001 1", pc_a, cov_a, rdy_a);
    end
    v2[0] = 3'b000;
    run_table("restart_second", v2);
  endtask

  task automatic test_xor();
    logic [2:0] v [4];
    v = '{3'b000, 3'b011, 3'b101, 3'b110};
    sel = 1; do_start();
    run_table("xor_pass", v);
  endtask

  initial begin
    rst = 1; start_a = 0; start_x = 0; valid_a = 0; valid_x = 0;
    sa = 0; sb_in = 0; sy = 0;
    test_reset();
    test_and_pass();
    test_and_fail();
    test_budget();
    test_reset_midrun();
    test_restart();
    test_xor();
    tick(); tick();
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: got %0d pending results expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
